tage_fold_hist: RTL and testbench

TAGE_FOLD_HIST -- requirements
Module: tage_fold_hist

---
 rtl/tage_pkg.sv | 26 ++
 rtl/fold_reg.sv | 39 +++
 rtl/tage_fold_hist.sv | 130 +++++++++++++
 tb/tb_tage_fold_hist.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/tage_pkg.sv
// Shared TAGE history-folding constants, per-table history lengths and typedefs.
// No logic; consumed by tage_fold_hist and its users.
// No flow control.
package tage_pkg;

    localparam int NUM_TABLES = 4;
    localparam int INDEX_LEN  = 10;
    localparam int TAG_LEN    = 8;

    // Geometric history lengths, shortest table first; each must fit in the global history.
    localparam int H [NUM_TABLES] = '{8, 16, 32, 64};

    typedef logic [INDEX_LEN-1:0] idx_t;
    typedef logic [TAG_LEN-1:0]   tag_t;

    typedef struct packed {
        idx_t               fi;
        tag_t               ft0;
        logic [TAG_LEN-2:0] ft1;
    } fold_state_t;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/fold_reg.sv
// One folded-history register: L-bit XOR-fold of the newest H history bits.
// Updates one cycle after a push or load; load takes priority over push.
// No backpressure: a push is accepted every cycle it is presented.
module fold_reg #(
    parameter int L = 8,
    parameter int H = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic         taken,
    input  logic         out_bit,
    input  logic         load,
    input  logic [L-1:0] load_dat,
    output logic [L-1:0] fold
);

    // The bit leaving the H-bit window lands at position H mod L after the rotate.
    localparam int POS = H % L;

    logic [L-1:0] fold_nxt;

    always_comb begin
        fold_nxt      = {fold[L-2:0], fold[L-1]};
        fold_nxt[0]   = fold_nxt[0] ^ taken;
        fold_nxt[POS] = fold_nxt[POS] ^ out_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fold <= '0;
        end else if (load) begin
            fold <= load_dat;
        end else if (we) begin
            fold <= fold_nxt;
        end
    end

endmodule

// File: rtl/tage_fold_hist.sv
// TAGE global history with per-table folded index/tag hashes and one checkpoint.
// Lookup latency 1 cycle; idx/tag hold when no lookup is presented.
// No backpressure: pushes, lookups and checkpoint operations are accepted every cycle.
module tage_fold_hist #(
    parameter int NUM_TABLES = tage_pkg::NUM_TABLES,
    parameter int GHIST_LEN  = 64,
    parameter int PHIST_LEN  = 16,
    parameter int INDEX_LEN  = tage_pkg::INDEX_LEN,
    parameter int TAG_LEN    = tage_pkg::TAG_LEN
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 we,
    input  logic                                 taken,
    input  logic [PHIST_LEN-1:0]                 phist,
    input  logic                                 lookup_valid,
    input  logic [31:0]                          lookup_pc,
    input  logic                                 ckpt_save,
    input  logic                                 ckpt_restore,
    output logic                                 out_valid,
    output logic [NUM_TABLES-1:0][INDEX_LEN-1:0] idx,
    output logic [NUM_TABLES-1:0][TAG_LEN-1:0]   tag
);

    logic [GHIST_LEN-1:0] ghist, snap_ghist;

    logic [NUM_TABLES-1:0][INDEX_LEN-1:0] fi,  snap_fi;
    logic [NUM_TABLES-1:0][TAG_LEN-1:0]   ft0, snap_ft0;
    logic [NUM_TABLES-1:0][TAG_LEN-2:0]   ft1, snap_ft1;

    logic [NUM_TABLES-1:0][INDEX_LEN-1:0] ph_m;
    logic [NUM_TABLES-1:0][INDEX_LEN-1:0] idx_nxt;
    logic [NUM_TABLES-1:0][TAG_LEN-1:0]   tag_nxt;

    // Bits that never feed a hash.
    logic unused_pc;
    logic unused_ph;
    assign unused_pc = ^{lookup_pc[31:INDEX_LEN+2], lookup_pc[1:0]};
    assign unused_ph = ^phist;

    // Restore wins over both push and save.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghist <= '0;
        end else if (ckpt_restore) begin
            ghist <= snap_ghist;
        end else if (we) begin
            ghist <= {ghist[GHIST_LEN-2:0], taken};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_ghist <= '0;
            snap_fi    <= '0;
            snap_ft0   <= '0;
            snap_ft1   <= '0;
        end else if (ckpt_save && !ckpt_restore) begin
            snap_ghist <= ghist;
            snap_fi    <= fi;
            snap_ft0   <= ft0;
            snap_ft1   <= ft1;
        end
    end

    for (genvar t = 0; t < NUM_TABLES; t++) begin : g_tbl
        localparam int HT = tage_pkg::H[t];
        localparam int PM = tage_pkg::min_int(HT, PHIST_LEN);

        fold_reg #(.L(INDEX_LEN), .H(HT)) u_fi (
            .clk      (clk),
            .rst      (rst),
            .we       (we),
            .taken    (taken),
            .out_bit  (ghist[HT-1]),
            .load     (ckpt_restore),
            .load_dat (snap_fi[t]),
            .fold     (fi[t])
        );

        fold_reg #(.L(TAG_LEN), .H(HT)) u_ft0 (
            .clk      (clk),
            .rst      (rst),
            .we       (we),
            .taken    (taken),
            .out_bit  (ghist[HT-1]),
            .load     (ckpt_restore),
            .load_dat (snap_ft0[t]),
            .fold     (ft0[t])
        );

        fold_reg #(.L(TAG_LEN-1), .H(HT)) u_ft1 (
            .clk      (clk),
            .rst      (rst),
            .we       (we),
            .taken    (taken),
            .out_bit  (ghist[HT-1]),
            .load     (ckpt_restore),
            .load_dat (snap_ft1[t]),
            .fold     (ft1[t])
        );

        // Short tables only see as much path history as they have global history.
        for (genvar b = 0; b < INDEX_LEN; b++) begin : g_ph
            if (b < PM) begin : g_on
                assign ph_m[t][b] = phist[b];
            end else begin : g_off
                assign ph_m[t][b] = 1'b0;
            end
        end

        assign idx_nxt[t] = lookup_pc[INDEX_LEN+1:2] ^ fi[t] ^ ph_m[t];
        assign tag_nxt[t] = lookup_pc[TAG_LEN+1:2] ^ ft0[t] ^ {ft1[t], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            idx       <= '0;
            tag       <= '0;
        end else begin
            out_valid <= lookup_valid;
            if (lookup_valid) begin
                idx <= idx_nxt;
                tag <= tag_nxt;
            end
        end
    end

endmodule

// File: tb/tb_tage_fold_hist.sv
// Directed bench for tage_fold_hist: reference history model plus hand-computed vectors.
module tb_tage_fold_hist;

    logic        clk = 1'b0;
    logic        rst, we, taken, lookup_valid, ckpt_save, ckpt_restore;
    logic [15:0] phist;
    logic [31:0] lookup_pc;
    logic        out_valid;
    logic [3:0][9:0] idx;
    logic [3:0][7:0] tag;

    always #5 clk = ~clk;

    tage_fold_hist dut (
        .clk          (clk),
        .rst          (rst),
        .we           (we),
        .taken        (taken),
        .phist        (phist),
        .lookup_valid (lookup_valid),
        .lookup_pc    (lookup_pc),
        .ckpt_save    (ckpt_save),
        .ckpt_restore (ckpt_restore),
        .out_valid    (out_valid),
        .idx          (idx),
        .tag          (tag)
    );

    int checks = 0;
    int errors = 0;

    localparam int HL [4] = '{8, 16, 32, 64};

    logic [63:0] g_m, snap_m;
    logic [9:0]  e_idx [4];
    logic [7:0]  e_tag [4];
    logic        e_vld;
    logic [9:0]  pre_idx [4];
    logic [7:0]  pre_tag [4];

    function automatic logic [9:0] xfold(input logic [63:0] h, input int hl, input int l);
        logic [9:0] r;
        r = '0;
        for (int i = 0; i < hl; i++) r[i % l] = r[i % l] ^ h[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic check_outs(input string nm);
        chk($sformatf("%s vld", nm), {31'd0, out_valid}, {31'd0, e_vld});
        for (int t = 0; t < 4; t++) begin
            chk($sformatf("%s idx%0d", nm, t), {22'd0, idx[t]}, {22'd0, e_idx[t]});
            chk($sformatf("%s tag%0d", nm, t), {24'd0, tag[t]}, {24'd0, e_tag[t]});
        end
    endtask

    task automatic cyc(input logic w, input logic tk, input logic sv, input logic rs,
                       input logic lv, input logic [31:0] pc, input logic [15:0] ph,
                       input string nm);
        logic [9:0] fi, f8, f7, mk;
        int m;
        rst = 1'b0; we = w; taken = tk; ckpt_save = sv; ckpt_restore = rs;
        lookup_valid = lv; lookup_pc = pc; phist = ph;
        if (lv) begin
            for (int t = 0; t < 4; t++) begin
                fi = xfold(g_m, HL[t], 10);
                f8 = xfold(g_m, HL[t], 8);
                f7 = xfold(g_m, HL[t], 7);
                m  = (HL[t] < 16) ? HL[t] : 16;
                mk = (m >= 10) ? 10'h3FF : 10'((1 << m) - 1);
                e_idx[t] = pc[11:2] ^ fi ^ (ph[9:0] & mk);
                e_tag[t] = pc[9:2] ^ f8[7:0] ^ {f7[6:0], 1'b0};
            end
        end
        e_vld = lv;
        if (rs) begin
            g_m = snap_m;
        end else begin
            if (sv) snap_m = g_m;
            if (w)  g_m = {g_m[62:0], tk};
        end
        @(posedge clk);
        #1;
        check_outs(nm);
    endtask

    // Reset is asserted together with every other control to show it overrides them.
    task automatic do_reset();
        rst = 1'b1; we = 1'b1; taken = 1'b1; ckpt_save = 1'b1; ckpt_restore = 1'b1;
        lookup_valid = 1'b1; lookup_pc = 32'hFFFF_FFFF; phist = 16'hFFFF;
        g_m = '0; snap_m = '0; e_vld = 1'b0;
        for (int t = 0; t < 4; t++) begin e_idx[t] = '0; e_tag[t] = '0; end
        @(posedge clk);
        #1;
        rst = 1'b0; we = 1'b0; taken = 1'b0; ckpt_save = 1'b0; ckpt_restore = 1'b0;
        lookup_valid = 1'b0; lookup_pc = '0; phist = '0;
        check_outs("reset");
    endtask

    task automatic hand_chk(input string nm, input logic [9:0] ei, input logic [7:0] et);
        for (int t = 0; t < 4; t++) begin
            chk($sformatf("%s hidx%0d", nm, t), {22'd0, idx[t]}, {22'd0, ei});
            chk($sformatf("%s htag%0d", nm, t), {24'd0, tag[t]}, {24'd0, et});
        end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; taken = 1'b0; ckpt_save = 1'b0; ckpt_restore = 1'b0;
        lookup_valid = 1'b0; lookup_pc = '0; phist = '0;
        repeat (2) @(posedge clk);
        do_reset();

        // Lookup on empty history: only the PC bits survive.
        cyc(0, 0, 0, 0, 1, 32'h0000_1004, 16'h0000, "rst_lookup");
        hand_chk("rst_lookup", 10'h001, 8'h01);
        cyc(0, 0, 0, 0, 0, 32'hDEAD_BEEF, 16'hFFFF, "hold");
        hand_chk("hold", 10'h001, 8'h01);

        // One taken push sets bit 0 of every fold.
        do_reset();
        cyc(1, 1, 0, 0, 0, 32'h0, 16'h0, "push1");
        cyc(0, 0, 0, 0, 1, 32'h0, 16'h0, "push1_lookup");
        hand_chk("push1", 10'h001, 8'h03);

        // Restore with no prior save returns to an all-zero history.
        cyc(0, 0, 0, 1, 0, 32'h0, 16'h0, "restore_nosave");
        cyc(0, 0, 0, 0, 1, 32'h0, 16'h0, "restore_nosave_lookup");
        hand_chk("restore_nosave", 10'h000, 8'h00);

        // Random history, including wrap-around past all history lengths.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            cyc(1, 1'($urandom_range(0, 1)), 0, 0, 1, $urandom, 16'($urandom), "rand");
            if (i % 7 == 6) cyc(0, 0, 0, 0, 0, $urandom, 16'($urandom), "rand_hold");
        end

        // Checkpoint round-trip.
        cyc(0, 0, 0, 0, 1, 32'h0000_2468, 16'h1357, "ckpt_pre");
        for (int t = 0; t < 4; t++) begin pre_idx[t] = e_idx[t]; pre_tag[t] = e_tag[t]; end
        cyc(0, 0, 1, 0, 0, 32'h0, 16'h0, "ckpt_save");
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 1, 32'h0000_2468, 16'h1357, "ckpt_push");
        cyc(0, 0, 0, 1, 0, 32'h0, 16'h0, "ckpt_restore");
        cyc(0, 0, 0, 0, 1, 32'h0000_2468, 16'h1357, "ckpt_post");
        for (int t = 0; t < 4; t++) begin
            chk($sformatf("ckpt idx%0d", t), {22'd0, idx[t]}, {22'd0, pre_idx[t]});
            chk($sformatf("ckpt tag%0d", t), {24'd0, tag[t]}, {24'd0, pre_tag[t]});
        end

        // Simultaneous events.
        cyc(1, 1, 0, 0, 0, 32'h0, 16'h0, "sim_push");
        cyc(1, 1, 0, 1, 1, 32'h0000_0ABC, 16'h00F0, "restore_we");
        cyc(0, 0, 0, 0, 1, 32'h0000_0ABC, 16'h00F0, "restore_we_chk");
        for (int i = 0; i < 3; i++) cyc(1, 1'(i & 1), 0, 0, 0, 32'h0, 16'h0, "sim_push2");
        cyc(0, 0, 1, 1, 0, 32'h0, 16'h0, "restore_save");
        cyc(1, 1, 0, 0, 0, 32'h0, 16'h0, "sim_push3");
        cyc(1, 0, 0, 0, 0, 32'h0, 16'h0, "sim_push3");
        cyc(0, 0, 0, 1, 0, 32'h0, 16'h0, "sim_restore");
        cyc(0, 0, 0, 0, 1, 32'h0000_1230, 16'h0000, "snap_unchanged");
        cyc(1, 1, 0, 0, 1, 32'h0000_7FFC, 16'hA5A5, "lookup_we");
        cyc(0, 0, 0, 0, 1, 32'h0000_7FFC, 16'hA5A5, "lookup_after_we");

        // Reset with a lookup in flight.
        cyc(1, 1, 0, 0, 1, 32'h0000_3330, 16'h0F0F, "pre_rst");
        do_reset();
        cyc(0, 0, 0, 0, 1, 32'h0, 16'h0, "post_rst_zero");
        hand_chk("post_rst_zero", 10'h000, 8'h00);
        cyc(0, 0, 0, 0, 1, 32'h0000_1004, 16'h0000, "post_rst");
        hand_chk("post_rst", 10'h001, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
